// File: rtl/mips_pipe_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mips_pipe_pkg : opcodes, sequencer state encoding and rt-usage decode
// Revision 1.0
// ---------------------------------------------------------------------------
package mips_pipe_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_MEM_WAIT   = 2'd2
  } state_t;

  // Instructions that read rt as a source operand (addi/lw write it instead)
  function automatic logic uses_rt(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ);
  endfunction

endpackage
`default_nettype wire

// File: rtl/load_use_detect.sv
`default_nettype none
// ---------------------------------------------------------------------------
// load_use_detect : combinational load-use hazard compare between EX and ID
// Revision 1.0
// ---------------------------------------------------------------------------
module load_use_detect (
  input  logic [5:0] id_op,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rt,
  output logic       hazard
);
  import mips_pipe_pkg::*;

  always_comb begin
    hazard = ex_mem_read && (ex_rt != 5'd0) &&
             ((ex_rt == id_rs) || ((ex_rt == id_rt) && uses_rt(id_op)));
  end

endmodule
`default_nettype wire

// File: rtl/hazard_stall_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hazard_stall_sequencer : per-cycle advance/hold/bubble control for the
// 5-stage pipeline, with perf counters and sticky memory-timeout flag
// Revision 1.0
// ---------------------------------------------------------------------------
module hazard_stall_sequencer #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int MEM_TIMEOUT       = 255,
  parameter int CNT_W             = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       id_op,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             ex_branch_taken,
  input  logic             dmem_busy,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_write,
  output logic             idex_bubble,
  output logic             exmem_write,
  output logic             memwb_bubble,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);
  import mips_pipe_pkg::*;

  localparam logic [2:0]       STALL_INIT  = 3'(LOAD_STALL_CYCLES - 1);
  localparam logic [7:0]       TIMEOUT_LIM = 8'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  state_t           state_q, state_d, eff_state;
  logic [2:0]       remain_q, remain_d;
  logic [7:0]       tmo_cnt_q, tmo_cnt_d;
  logic             mem_timeout_q, mem_timeout_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;
  logic             hazard;

  load_use_detect u_load_use_detect (
    .id_op       (id_op),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .ex_mem_read (ex_mem_read),
    .ex_rt       (ex_rt),
    .hazard      (hazard)
  );

  always_comb begin
    pc_write      = 1'b1;
    ifid_write    = 1'b1;
    ifid_flush    = 1'b0;
    idex_write    = 1'b1;
    idex_bubble   = 1'b0;
    exmem_write   = 1'b1;
    memwb_bubble  = 1'b0;
    remain_d      = remain_q;
    tmo_cnt_d     = 8'd0;
    mem_timeout_d = mem_timeout_q;
    // Leaving MEM_WAIT behaves as whichever state the wait interrupted
    eff_state = state_q;
    if (state_q == ST_MEM_WAIT) begin
      eff_state = (remain_q != 3'd0) ? ST_LOAD_STALL : ST_RUN;
    end
    state_d = eff_state;

    if (rst) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      ifid_flush   = 1'b1;
      idex_bubble  = 1'b1;
      memwb_bubble = 1'b1;
      state_d      = ST_RUN;
      remain_d     = 3'd0;
    end else if (dmem_busy) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      idex_write   = 1'b0;
      exmem_write  = 1'b0;
      memwb_bubble = 1'b1;
      state_d      = ST_MEM_WAIT;
      tmo_cnt_d    = (tmo_cnt_q == 8'hFF) ? tmo_cnt_q : tmo_cnt_q + 8'd1;
      if (tmo_cnt_d >= TIMEOUT_LIM) mem_timeout_d = 1'b1;
    end else if (ex_branch_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      state_d     = ST_RUN;
      remain_d    = 3'd0;
    end else if (eff_state == ST_LOAD_STALL) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      remain_d    = (remain_q == 3'd0) ? 3'd0 : remain_q - 3'd1;
      state_d     = (remain_d != 3'd0) ? ST_LOAD_STALL : ST_RUN;
    end else if (hazard) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      remain_d    = STALL_INIT;
      state_d     = (STALL_INIT != 3'd0) ? ST_LOAD_STALL : ST_RUN;
    end else if (id_op == OP_J) begin
      ifid_flush = 1'b1;
    end
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (!pc_write && (stall_cycles_q != CNT_MAX)) stall_cycles_d = stall_cycles_q + CNT_W'(1);
    if (ifid_flush && (flush_count_q != CNT_MAX)) flush_count_d = flush_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_RUN;
      remain_q       <= 3'd0;
      tmo_cnt_q      <= 8'd0;
      mem_timeout_q  <= 1'b0;
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      remain_q       <= remain_d;
      tmo_cnt_q      <= tmo_cnt_d;
      mem_timeout_q  <= mem_timeout_d;
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign mem_timeout  = mem_timeout_q;
  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;

endmodule
`default_nettype wire
